// File: rtl/dmem_wait_resp.sv
// Data-memory responder for the MEM-stage RAM port.
// One access at a time, fixed wait states, byte-enable word storage.
module dmem_wait_resp #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [3:0]            be_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ready_o,
  output logic                  err_o,
  output logic                  stallreq_o
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            be_q;

  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [3:0]            acc_be;
  logic                  misal;
  logic                  oor;
  logic                  err_nx;
  logic                  exec;
  logic [IW-1:0]         widx;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // zero wait states execute straight from the live inputs
  always_comb begin
    acc_we   = we_q;
    acc_addr = addr_q;
    acc_data = data_q;
    acc_be   = be_q;
    if (state == IDLE) begin
      acc_we   = we_i;
      acc_addr = addr_i;
      acc_data = data_i;
      acc_be   = be_i;
    end
  end

  always_comb begin
    misal = 1'b0;
    unique case (acc_be)
      4'b1111:          misal = |acc_addr[1:0];
      4'b0011, 4'b1100: misal = acc_addr[0];
      4'b0000, 4'b0001,
      4'b0010, 4'b0100,
      4'b1000:          misal = 1'b0;
      default:          misal = |acc_addr[1:0];
    endcase
  end

  assign oor    = |acc_addr[ADDR_WIDTH-1:IW+2];
  assign err_nx = misal | oor;
  assign widx   = acc_addr[IW+1:2];

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    stallreq_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i) begin
          stallreq_o = 1'b1;
          cnt_nx     = 4'(WAIT_CYCLES);
          state_nx   = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        stallreq_o = 1'b1;
        cnt_nx     = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign exec    = (state_nx == RESP) && (state != RESP);
  assign ready_o = (state == RESP);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      data_o <= '0;
      err_o  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req_i) begin
        we_q   <= we_i;
        addr_q <= addr_i;
        data_q <= data_i;
        be_q   <= be_i;
      end
      if (exec) begin
        err_o  <= err_nx;
        data_o <= (!acc_we && !err_nx) ? mem[widx] : '0;
      end else if (state == RESP) begin
        err_o  <= 1'b0;
        data_o <= '0;
      end
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk_i) begin
    if (exec && acc_we && !err_nx) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[widx][8*b +: 8] <= acc_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_wait_resp.sv
// Directed bench for dmem_wait_resp.
// Two builds: WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_dmem_wait_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;

  logic [31:0] rd_a, rd_b;
  logic        rdy_a, rdy_b;
  logic        err_a, err_b;
  logic        st_a, st_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_wait_resp #(.WAIT_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_a),
    .we_i(we), .addr_i(addr), .data_i(wdata), .be_i(be),
    .data_o(rd_a), .ready_o(rdy_a), .err_o(err_a),
    .stallreq_o(st_a)
  );

  dmem_wait_resp #(.WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_b),
    .we_i(we), .addr_i(addr), .data_i(wdata), .be_i(be),
    .data_o(rd_b), .ready_o(rdy_b), .err_o(err_b),
    .stallreq_o(st_b)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic rdy(input bit s);
    return s ? rdy_b : rdy_a;
  endfunction

  function automatic logic stl(input bit s);
    return s ? st_b : st_a;
  endfunction

  task automatic run(input bit s, input vec_t v,
                     input int w, input string nm);
    int  stalls;
    bit  seen;
    stalls = 0;
    seen   = 1'b0;
    @(negedge clk);
    we    = v.we;
    addr  = v.addr;
    wdata = v.data;
    be    = v.be;
    if (s) req_b = 1'b1;
    else   req_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rdy(s)) begin
        seen = 1'b1;
        break;
      end
      if (stl(s)) stalls++;
      @(negedge clk);
    end
    chk({nm, " ready"}, 32'(seen), 32'd1);
    chk({nm, " stalls"}, 32'(stalls), 32'(w + 1));
    chk({nm, " stall_resp"}, 32'(stl(s)), 32'd0);
    chk({nm, " data"}, s ? rd_b : rd_a, v.exp_data);
    chk({nm, " err"}, 32'(s ? err_b : err_a), 32'(v.exp_err));
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    #1;
    chk({nm, " pulse"}, 32'(rdy(s)), 32'd0);
  endtask

  initial begin
    int pulses;
    vec_t v;

    tbl[0]  = '{1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        0};
    tbl[1]  = '{0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 0};
    tbl[2]  = '{1, 32'h10,   32'h0000AA00, 4'h2, 32'h0,        0};
    tbl[3]  = '{0, 32'h10,   32'h0,        4'hF, 32'hDEADAAEF, 0};
    tbl[4]  = '{0, 32'h12,   32'h0,        4'hF, 32'h0,        1};
    tbl[5]  = '{1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        0};
    tbl[6]  = '{1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1};
    tbl[7]  = '{0, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 0};
    tbl[8]  = '{1, 32'h13,   32'h77000000, 4'h8, 32'h0,        0};
    tbl[9]  = '{1, 32'h11,   32'h00005555, 4'h3, 32'h0,        1};
    tbl[10] = '{1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0,        0};
    tbl[11] = '{0, 32'h10,   32'h0,        4'hF, 32'h77ADAAEF, 0};
    tbl[12] = '{1, 32'hFFC,  32'hA5A55A5A, 4'hF, 32'h0,        0};
    tbl[13] = '{0, 32'hFFC,  32'h0,        4'hF, 32'hA5A55A5A, 0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst ready", 32'(rdy_a), 32'd0);
    chk("rst data", rd_a, 32'd0);
    chk("rst err", 32'(err_a), 32'd0);
    chk("rst stall", 32'(st_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle stall", 32'(st_a), 32'd0);
    chk("idle ready", 32'(rdy_a), 32'd0);

    for (int i = 0; i < 14; i++) begin
      run(1'b0, tbl[i], 2, $sformatf("vec%0d", i));
    end

    v = '{1, 32'h40, 32'h01020304, 4'hF, 32'h0, 0};
    run(1'b1, v, 0, "w0 store");
    v = '{0, 32'h40, 32'h0, 4'hF, 32'h01020304, 0};
    run(1'b1, v, 0, "w0 load");

    v = '{1, 32'h20, 32'h11111111, 4'hF, 32'h0, 0};
    run(1'b0, v, 2, "pre20");

    @(negedge clk);
    we    = 1'b1;
    addr  = 32'h20;
    wdata = 32'h22222222;
    be    = 4'hF;
    req_a = 1'b1;
    @(negedge clk);
    #1;
    chk("midwait stall", 32'(st_a), 32'd1);
    req_a = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst stall", 32'(st_a), 32'd0);
    chk("rst ready2", 32'(rdy_a), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (rdy_a) pulses++;
    end
    chk("abandon pulses", 32'(pulses), 32'd0);
    v = '{0, 32'h20, 32'h0, 4'hF, 32'h11111111, 0};
    run(1'b0, v, 2, "post20");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
